// File: rtl/card_match_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : card_flip_pkg
//  Purpose  : Shared sizes, FSM state encoding and card-value extraction for
//             the card match engine.
//  Contents : NUM_CARDS, VAL_W, IDX_W, MAP_W, state_t, card_val()
//  Revision : 1.0  initial release
// ============================================================================
package card_flip_pkg;

    localparam int NUM_CARDS = 16;
    localparam int VAL_W     = 3;
    localparam int IDX_W     = 4;
    localparam int MAP_W     = 48;

    typedef enum logic [2:0] {
        EMPTY       = 3'd0,
        WAIT_FIRST  = 3'd1,
        WAIT_SECOND = 3'd2,
        COMPARE     = 3'd3,
        HOLD        = 3'd4,
        WON         = 3'd5
    } state_t;

    // The map is an ascending vector, so map[3*idx] (the lowest index of the
    // slice) lands in the MSB of the returned value.
    function automatic logic [VAL_W-1:0] card_val(input logic [0:MAP_W-1] map,
                                                  input logic [IDX_W-1:0] idx);
        return map[VAL_W*int'(idx) +: VAL_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/card_match_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : card_match_engine_if
//  Purpose  : Groups the map-load, selection and display/status signals of
//             the card match engine.
//  Ports    : master drives map_in/map_load/sel_card/sel_valid and observes
//             the rest; slave (the engine) is the mirror image.
//  Revision : 1.0  initial release
// ============================================================================
interface card_match_engine_if;
    import card_flip_pkg::*;

    logic [0:MAP_W-1]     map_in;
    logic                 map_load;
    logic [IDX_W-1:0]     sel_card;
    logic                 sel_valid;
    logic                 sel_ready;
    logic [NUM_CARDS-1:0] face_up;
    logic [NUM_CARDS-1:0] matched;
    logic [0:MAP_W-1]     map_out;
    logic                 match_pulse;
    logic                 mismatch_pulse;
    logic [7:0]           attempts;
    logic                 game_won;

    modport master (
        output map_in, map_load, sel_card, sel_valid,
        input  sel_ready, face_up, matched, map_out,
               match_pulse, mismatch_pulse, attempts, game_won
    );

    modport slave (
        input  map_in, map_load, sel_card, sel_valid,
        output sel_ready, face_up, matched, map_out,
               match_pulse, mismatch_pulse, attempts, game_won
    );

endinterface
`default_nettype wire

// File: rtl/card_match_engine_mismatch_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mismatch_timer
//  Purpose  : Down-counter that times how long a mismatched pair stays
//             face-up. load presets MISMATCH_HOLD-1, run decrements toward 0,
//             expire is high whenever the count is 0.
//  Ports    : clk, reset (async, active-high), clear, load, run -> expire
//  Revision : 1.0  initial release
// ============================================================================
module mismatch_timer #(
    parameter int MISMATCH_HOLD = 25000000
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic load,
    input  wire logic run,
    output logic      expire
);

    localparam int               CNT_W    = $clog2(MISMATCH_HOLD + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MISMATCH_HOLD - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (run && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule
`default_nettype wire

// File: rtl/card_match_engine.sv
`default_nettype none
// ============================================================================
//  Module   : card_match_engine
//  Purpose  : Memory-game logic. Latches the 48-bit card map, takes two card
//             selections, compares their values, marks matches or shows a
//             mismatched pair for MISMATCH_HOLD cycles, and flags the win.
//  Ports    : clk, reset (async, active-high),
//             bus (card_match_engine_if.slave): map_in/map_load/sel_card/
//             sel_valid in; sel_ready/face_up/matched/map_out/match_pulse/
//             mismatch_pulse/attempts/game_won out
//  Revision : 1.0  initial release
// ============================================================================
module card_match_engine
    import card_flip_pkg::*;
#(
    parameter int MISMATCH_HOLD = 25000000
) (
    input  wire logic           clk,
    input  wire logic           reset,
    card_match_engine_if.slave  bus
);

    state_t               state_q, state_d;
    logic [0:MAP_W-1]     map_q, map_d;
    logic [NUM_CARDS-1:0] face_up_q, face_up_d;
    logic [NUM_CARDS-1:0] matched_q, matched_d;
    logic [IDX_W-1:0]     first_q, first_d;
    logic [IDX_W-1:0]     second_q, second_d;
    logic [7:0]           attempts_q, attempts_d;
    logic                 match_q, match_d;
    logic                 mismatch_q, mismatch_d;

    logic timer_clear;
    logic timer_load;
    logic timer_run;
    logic timer_expire;
    logic accept;

    mismatch_timer #(
        .MISMATCH_HOLD (MISMATCH_HOLD)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .load   (timer_load),
        .run    (timer_run),
        .expire (timer_expire)
    );

    // A card already face-up (the pending first pick or a matched card) can
    // never be picked again; such strobes are simply dropped.
    assign accept = bus.sel_valid && !bus.map_load &&
                    ((state_q == WAIT_FIRST) || (state_q == WAIT_SECOND)) &&
                    !face_up_q[bus.sel_card];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            map_q      <= '0;
            face_up_q  <= '0;
            matched_q  <= '0;
            first_q    <= '0;
            second_q   <= '0;
            attempts_q <= '0;
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            map_q      <= map_d;
            face_up_q  <= face_up_d;
            matched_q  <= matched_d;
            first_q    <= first_d;
            second_q   <= second_d;
            attempts_q <= attempts_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        map_d       = map_q;
        face_up_d   = face_up_q;
        matched_d   = matched_q;
        first_d     = first_q;
        second_d    = second_q;
        attempts_d  = attempts_q;
        match_d     = 1'b0;
        mismatch_d  = 1'b0;
        timer_clear = 1'b0;
        timer_load  = 1'b0;
        timer_run   = 1'b0;

        if (bus.map_load) begin
            // New game overrides whatever is in progress, including HOLD.
            map_d       = bus.map_in;
            face_up_d   = '0;
            matched_d   = '0;
            attempts_d  = '0;
            timer_clear = 1'b1;
            state_d     = WAIT_FIRST;
        end else begin
            unique case (state_q)
                WAIT_FIRST: begin
                    if (accept) begin
                        face_up_d[bus.sel_card] = 1'b1;
                        first_d                 = bus.sel_card;
                        state_d                 = WAIT_SECOND;
                    end
                end
                WAIT_SECOND: begin
                    if (accept) begin
                        face_up_d[bus.sel_card] = 1'b1;
                        second_d                = bus.sel_card;
                        state_d                 = COMPARE;
                    end
                end
                COMPARE: begin
                    if (attempts_q != 8'hFF) begin
                        attempts_d = attempts_q + 8'd1;
                    end
                    if (card_val(map_q, first_q) == card_val(map_q, second_q)) begin
                        matched_d[first_q]  = 1'b1;
                        matched_d[second_q] = 1'b1;
                        match_d             = 1'b1;
                        state_d             = (matched_d == '1) ? WON : WAIT_FIRST;
                    end else begin
                        mismatch_d = 1'b1;
                        timer_load = 1'b1;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (timer_expire) begin
                        face_up_d[first_q]  = 1'b0;
                        face_up_d[second_q] = 1'b0;
                        state_d             = WAIT_FIRST;
                    end else begin
                        timer_run = 1'b1;
                    end
                end
                WON:     state_d = WON;
                EMPTY:   state_d = EMPTY;
                default: state_d = EMPTY;
            endcase
        end
    end

    assign bus.sel_ready      = (state_q == WAIT_FIRST) || (state_q == WAIT_SECOND);
    assign bus.game_won       = (state_q == WON);
    assign bus.face_up        = face_up_q;
    assign bus.matched        = matched_q;
    assign bus.map_out        = map_q;
    assign bus.match_pulse    = match_q;
    assign bus.mismatch_pulse = mismatch_q;
    assign bus.attempts       = attempts_q;

endmodule
`default_nettype wire

// File: tb/tb_card_match_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_card_match_engine
//  Purpose  : Self-checking bench for card_match_engine. A cycle-scheduled
//             game model predicts every output; directed selections exercise
//             match, mismatch/hold, dropped selections, win, reload and
//             asynchronous reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_card_match_engine;
    import card_flip_pkg::*;

    localparam int         HOLD      = 4;
    // card i value = i>>1, card 0 in the leftmost (index 0) bits
    localparam logic [0:47] BENCH_MAP = 48'h0094_9B92_DDBF;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    card_match_engine_if bus();

    card_match_engine #(
        .MISMATCH_HOLD (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Game state as a player sees it; timing is tracked with absolute cycle
    // numbers at which the comparison and the flip-back must happen.
    logic [15:0] m_face, m_matched;
    logic [47:0] m_map;
    int          m_attempts;
    logic        m_match, m_mismatch;
    logic        loaded, have_first, pending, flipping;
    int          m_first, m_second;
    longint      cyc, cmp_cyc, flip_cyc;

    function automatic int value_of(input logic [47:0] map, input int idx);
        return int'((map >> (45 - 3 * idx)) & 48'd7);
    endfunction

    function automatic logic m_ready();
        return loaded && !pending && !flipping && (m_matched != 16'hFFFF);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_face = '0; m_matched = '0; m_map = '0; m_attempts = 0;
            m_match = 0; m_mismatch = 0; loaded = 0; have_first = 0;
            pending = 0; flipping = 0; cyc = 0; cmp_cyc = -1; flip_cyc = -1;
            m_first = 0; m_second = 0;
        end else begin
            cyc++;
            m_match = 0;
            m_mismatch = 0;
            if (bus.map_load) begin
                m_map = bus.map_in;
                m_face = '0; m_matched = '0; m_attempts = 0;
                loaded = 1; have_first = 0; pending = 0; flipping = 0;
            end else if (pending && cyc == cmp_cyc) begin
                pending = 0;
                if (m_attempts < 255) m_attempts++;
                if (value_of(m_map, m_first) == value_of(m_map, m_second)) begin
                    m_matched[m_first]  = 1'b1;
                    m_matched[m_second] = 1'b1;
                    m_match = 1;
                end else begin
                    m_mismatch = 1;
                    flipping = 1;
                    flip_cyc = cyc + HOLD;
                end
            end else if (flipping && cyc == flip_cyc) begin
                m_face[m_first]  = 1'b0;
                m_face[m_second] = 1'b0;
                flipping = 0;
            end else if (m_ready() && bus.sel_valid && !m_face[bus.sel_card]) begin
                m_face[bus.sel_card] = 1'b1;
                if (!have_first) begin
                    m_first = int'(bus.sel_card);
                    have_first = 1;
                end else begin
                    m_second = int'(bus.sel_card);
                    have_first = 0;
                    pending = 1;
                    cmp_cyc = cyc + 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("face_up",        bus.face_up,        m_face);
            chk("matched",        bus.matched,        m_matched);
            chk("map_out",        bus.map_out,        m_map);
            chk("attempts",       bus.attempts,       m_attempts[7:0]);
            chk("match_pulse",    bus.match_pulse,    m_match);
            chk("mismatch_pulse", bus.mismatch_pulse, m_mismatch);
            chk("sel_ready",      bus.sel_ready,      m_ready());
            chk("game_won",       bus.game_won,       loaded && (m_matched == 16'hFFFF));
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sel(input int c);
        bus.sel_card  = 4'(c);
        bus.sel_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.sel_valid = 1'b0;
    endtask

    task automatic load_map(input logic [0:47] map);
        bus.map_in   = map;
        bus.map_load = 1'b1;
        @(posedge clk);
        #1;
        bus.map_load = 1'b0;
    endtask

    int pairs [6][2] = '{'{2, 3}, '{6, 7}, '{8, 9}, '{10, 11}, '{12, 13}, '{14, 15}};

    initial begin
        bus.map_in    = '0;
        bus.map_load  = 1'b0;
        bus.sel_card  = '0;
        bus.sel_valid = 1'b0;
        #1 reset = 1'b1;
        idle(3);
        chk("rst_face_up",  bus.face_up,   16'h0000);
        chk("rst_sel_ready", bus.sel_ready, 1'b0);
        reset = 1'b0;
        idle(2);
        chk("preload_map_out",   bus.map_out,   48'h0);
        chk("preload_sel_ready", bus.sel_ready, 1'b0);
        chk("preload_game_won",  bus.game_won,  1'b0);

        load_map(BENCH_MAP);
        chk("load_map_out",   bus.map_out,   48'h0094_9B92_DDBF);
        chk("load_sel_ready", bus.sel_ready, 1'b1);

        // First pair: cards 0 and 1 (both value 0) match.
        sel(0);
        chk("first_face",  bus.face_up,   16'h0001);
        chk("first_ready", bus.sel_ready, 1'b1);
        sel(1);
        chk("second_ready", bus.sel_ready, 1'b0);
        idle(1);
        chk("m01_pulse",    bus.match_pulse, 1'b1);
        chk("m01_matched",  bus.matched,     16'h0003);
        chk("m01_attempts", bus.attempts,    8'd1);
        chk("m01_ready",    bus.sel_ready,   1'b1);

        // Cards 2 (value 1) and 4 (value 2) mismatch; a pick during the hold
        // window must be ignored.
        sel(2);
        sel(4);
        idle(1);
        chk("mm_pulse",    bus.mismatch_pulse, 1'b1);
        chk("mm_attempts", bus.attempts,       8'd2);
        chk("mm_face",     bus.face_up,        16'h0017);
        sel(6);
        idle(2);
        chk("hold_face",  bus.face_up,   16'h0017);
        chk("hold_ready", bus.sel_ready, 1'b0);
        idle(1);
        chk("flip_face",  bus.face_up,   16'h0003);
        chk("flip_ready", bus.sel_ready, 1'b1);

        // Repeated and already-matched picks are dropped; (5,4) matches.
        sel(5);
        sel(5);
        sel(0);
        chk("drop_ready", bus.sel_ready, 1'b1);
        sel(4);
        idle(1);
        chk("m54_matched",  bus.matched,  16'h0033);
        chk("m54_attempts", bus.attempts, 8'd3);

        for (int p = 0; p < 6; p++) begin
            sel(pairs[p][0]);
            sel(pairs[p][1]);
            idle(1);
        end
        chk("won_level",    bus.game_won,  1'b1);
        chk("won_matched",  bus.matched,   16'hFFFF);
        chk("won_attempts", bus.attempts,  8'd9);
        chk("won_ready",    bus.sel_ready, 1'b0);
        sel(3);
        idle(2);
        chk("won_hold_level",    bus.game_won, 1'b1);
        chk("won_hold_attempts", bus.attempts, 8'd9);

        load_map(BENCH_MAP);
        chk("reload_won",      bus.game_won, 1'b0);
        chk("reload_matched",  bus.matched,  16'h0000);
        chk("reload_attempts", bus.attempts, 8'd0);

        // Reset while the mismatch pulse is up and HOLD has begun.
        sel(2);
        sel(4);
        idle(1);
        chk("pre_rst_pulse", bus.mismatch_pulse, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_hold_pulse", bus.mismatch_pulse, 1'b0);
        chk("rst_hold_face",  bus.face_up,        16'h0000);
        chk("rst_hold_map",   bus.map_out,        48'h0);
        chk("rst_hold_ready", bus.sel_ready,      1'b0);
        idle(2);
        reset = 1'b0;
        idle(1);

        // Load together with a selection strobe: load wins, pick dropped.
        bus.map_in    = BENCH_MAP;
        bus.map_load  = 1'b1;
        bus.sel_card  = 4'd7;
        bus.sel_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.map_load  = 1'b0;
        bus.sel_valid = 1'b0;
        chk("ld_sel_face",  bus.face_up,   16'h0000);
        chk("ld_sel_ready", bus.sel_ready, 1'b1);
        chk("ld_sel_map",   bus.map_out,   48'h0094_9B92_DDBF);
        sel(7);
        chk("after_ld_face", bus.face_up, 16'h0080);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/card_match_engine.md
# card_match_engine

Game-logic consumer of the 48-bit card map produced by the random assignment block. It latches the map on the generator's `done` pulse and accepts player card selections two at a time. It compares the two selected 3-bit card values, then either marks the pair matched or holds both cards face-up for a fixed time before flipping them back. Its outputs drive the VGA/LED display and the win indication.

## Interface
Parameters:
- MISMATCH_HOLD, default 25000000: cycles both mismatched cards stay face-up (0.5 s at 50 MHz). Minimum 1; benches use 4.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- map_in  in  [0:47]  card map; card i value = map_in[3i +: 3], map_in[3i] is the MSB
- map_load  in  1  one-cycle pulse; latch map_in and start a new game (wire to generator `done`)
- sel_card  in  4  index of the card the player selects
- sel_valid  in  1  one-cycle selection strobe
- sel_ready  out  1  high when a selection will be accepted (WAIT_FIRST, WAIT_SECOND)
- face_up  out  16  bit i = card i currently shown (includes matched cards)
- matched  out  16  bit i = card i permanently matched
- map_out  out  [0:47]  registered copy of the latched map
- match_pulse  out  1  one-cycle pulse: compared pair matched
- mismatch_pulse  out  1  one-cycle pulse: compared pair differed
- attempts  out  8  pair comparisons this game, saturating at 255
- game_won  out  1  level, high while all 16 cards are matched

## Operation
- States:
  - EMPTY: after reset, no map loaded.
  - WAIT_FIRST
  - WAIT_SECOND
  - COMPARE
  - HOLD
  - WON
- map_load in any state has highest priority:
  - map_out <= map_in.
  - face_up, matched and attempts are cleared; the hold counter is cleared.
  - Next state is WAIT_FIRST.
  - Any sel_valid in the same cycle is ignored.
- A selection is accepted only when all of the following hold:
  - the state is WAIT_FIRST or WAIT_SECOND,
  - sel_valid = 1,
  - face_up[sel_card] = 0.
- A selection that fails these conditions is dropped silently, with no state or output change. This covers re-selecting the first card and selecting a matched card.
- WAIT_FIRST: on accept, set face_up[sel_card], store first_idx, go to WAIT_SECOND.
- WAIT_SECOND: on accept, set face_up[sel_card], store second_idx, go to COMPARE.
- COMPARE (one cycle): compare the 3-bit values at first_idx and second_idx; attempts increments, saturating at 255.
  - Equal: set matched[first_idx] and matched[second_idx]; pulse match_pulse. Next state is WON if matched becomes 16'hFFFF, else WAIT_FIRST.
  - Unequal: pulse mismatch_pulse; load hold counter = MISMATCH_HOLD-1; go to HOLD.
- HOLD: decrement the counter. At 0, clear face_up[first_idx] and face_up[second_idx] and go to WAIT_FIRST.
- WON: game_won = 1; selections are ignored until map_load.
- Matching is by value equality only; the map is not checked for pair structure.

## Timing
- Reset values: all outputs 0, state EMPTY, counter 0.
- Accepting the first selection at edge N: face_up bit visible after N; sel_ready stays 1.
- Accepting the second selection at edge M:
  - face_up visible after M; sel_ready = 0 from M until the game returns to WAIT_FIRST.
  - match_pulse/mismatch_pulse and the attempts update are high/visible in the cycle after edge M+1; matched bits update at M+1.
  - Match: sel_ready = 1 again after M+1.
  - Mismatch: the cards flip back after edge M+1+MISMATCH_HOLD, and sel_ready rises at that same edge.
- map_load at edge L: map_out and cleared state visible after L; sel_ready = 1 after L.
- Reset asserted mid-HOLD or mid-COMPARE immediately forces reset values; no pulse is emitted.
- Hold counter width = $clog2(MISMATCH_HOLD+1).

## Structure
- Package card_flip_pkg:
  - NUM_CARDS = 16, VAL_W = 3, IDX_W = 4, MAP_W = 48.
  - State enum.
  - Function card_val(map, idx) returning map[3*idx +: 3].
- Sub-module mismatch_timer: load/decrement counter parameterised by MISMATCH_HOLD; outputs expire.
- Everything else lives in card_match_engine.

## Test plan
Bench map: card i value = i>>1 (cards 0,1 = 3'b000; cards 14,15 = 3'b111); MISMATCH_HOLD = 4.
- Reset, then map_load -> all outputs 0 before the load; after the load map_out equals the bench map and sel_ready = 1.
- Select 0 then 1 -> face_up = 16'h8000|16'h4000 (bits 0,1 in [15:0] numbering: 16'h0003), one match_pulse, matched = 16'h0003, attempts = 1.
- Select 2 then 4 -> one mismatch_pulse; face_up[2] and face_up[4] held for exactly 4 cycles after COMPARE, then cleared; attempts = 2; sel_ready low for that window.
- Select 5, then 5 again, then matched card 0, then 4 -> the repeats and card 0 are ignored, and pair (5,4) matches.
- Match all 8 pairs -> game_won = 1 after the last COMPARE; further sel_valid has no effect. map_load then clears game_won, matched and attempts.
- Assert reset during HOLD and map_load concurrent with sel_valid -> reset values are restored immediately; the load wins and the selection is dropped.
